// File: rtl/axis_red_pitaya_adc_idelay_trainer_if.sv
// rtl/axis_red_pitaya_adc_idelay_trainer_if.sv - CE-mask and sample streams between IDELAY trainer and ADC receiver
//   m_axis_tdata/tvalid/tready : 28-bit CE-pulse mask, trainer -> receiver (one beat = one tap increment)
//   s_axis_tdata/tvalid        : 64-bit sample stream, receiver -> trainer (16 bits per channel)
//   master modport = trainer side, slave modport = receiver side
interface axis_red_pitaya_adc_idelay_trainer_if;
   logic [27:0] m_axis_tdata;
   logic        m_axis_tvalid;
   logic        m_axis_tready;
   logic [63:0] s_axis_tdata;
   logic        s_axis_tvalid;

   modport master (
      output m_axis_tdata, m_axis_tvalid,
      input  m_axis_tready,
      input  s_axis_tdata, s_axis_tvalid
   );

   modport slave (
      input  m_axis_tdata, m_axis_tvalid,
      output m_axis_tready,
      output s_axis_tdata, s_axis_tvalid
   );
endinterface

// File: rtl/axis_red_pitaya_adc_idelay_trainer.sv
// rtl/axis_red_pitaya_adc_idelay_trainer.sv - sweeps 28 ADC lanes over 32 IDELAY taps and centres each in its widest passing window
//   aclk, aresetn : clock, asynchronous active-low reset
//   start         : one-cycle training request (ignored while busy)
//   busy, done    : training in progress / finished (done held until next start)
//   lane_ok       : per-lane flag, best window >= MIN_WINDOW taps
//   lane_tap      : per-lane final offset, lane L at [5L+4:5L]
//   bus           : CE-mask master and sample-stream slave toward the receiver
module axis_red_pitaya_adc_idelay_trainer #(
   parameter logic [13:0] PATTERN       = 14'h2AAA,
   parameter int          SETTLE_CYCLES = 16,
   parameter int          NUM_SAMPLES   = 64,
   parameter int          MIN_WINDOW    = 4
) (
   input  logic         aclk,
   input  logic         aresetn,
   input  logic         start,
   output logic         busy,
   output logic         done,
   output logic [27:0]  lane_ok,
   output logic [139:0] lane_tap,
   axis_red_pitaya_adc_idelay_trainer_if.master bus
);

   typedef enum logic [2:0] {IDLE, SETTLE, CHECK, EVAL, STEP, CALC, MOVE, DONE} state_t;

   localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
   localparam logic [9:0] SAMPLE_LAST = 10'(NUM_SAMPLES - 1);

   state_t state, state_nxt;

   logic [4:0]       tap;
   logic [7:0]       settle_cnt;
   logic [9:0]       sample_cnt;
   logic [27:0]      fail;
   logic [27:0][5:0] cur_len, best_len;
   logic [27:0][4:0] cur_start, best_start, remaining;

   logic [3:0][13:0] mism;
   logic [27:0]      lane_bad;
   logic [27:0]      move_mask;
   logic [27:0]      calc_ok;
   logic [27:0][4:0] calc_rem;
   logic             accept;
   logic             unused_hi;

   // The receiver inverts raw bits 12:0 on the way in; bit 13 arrives true.
   always_comb begin
      mism     = '0;
      lane_bad = '0;
      for (int c = 0; c < 4; c++) begin
         mism[c] = {bus.s_axis_tdata[16*c+13], ~bus.s_axis_tdata[16*c +: 13]} ^ PATTERN;
         for (int k = 0; k < 7; k++) begin
            lane_bad[7*c+k] = |mism[c][2*k +: 2];
         end
      end
   end

   assign unused_hi = ^{bus.s_axis_tdata[63:62], bus.s_axis_tdata[47:46],
                        bus.s_axis_tdata[31:30], bus.s_axis_tdata[15:14]};

   always_comb begin
      move_mask = '0;
      calc_ok   = '0;
      calc_rem  = '0;
      for (int l = 0; l < 28; l++) begin
         move_mask[l] = |remaining[l];
         calc_ok[l]   = best_len[l] >= 6'(MIN_WINDOW);
         // Window centre, rounding toward the start; never exceeds tap 31.
         calc_rem[l]  = calc_ok[l] ? best_start[l] + 5'((best_len[l] - 6'd1) >> 1) : 5'd0;
      end
   end

   assign accept = bus.m_axis_tvalid && bus.m_axis_tready;
   assign busy   = (state != IDLE) && (state != DONE);
   assign done   = (state == DONE);

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt          = state;
      bus.m_axis_tvalid  = 1'b0;
      bus.m_axis_tdata   = '0;
      case (state)
         IDLE, DONE: if (start) state_nxt = SETTLE;
         SETTLE:     if (settle_cnt == SETTLE_LAST) state_nxt = CHECK;
         CHECK:      if (bus.s_axis_tvalid && sample_cnt == SAMPLE_LAST) state_nxt = EVAL;
         EVAL:       state_nxt = STEP;
         STEP: begin
            bus.m_axis_tvalid = 1'b1;
            bus.m_axis_tdata  = '1;
            // The 32nd increment wraps every lane back to its starting tap.
            if (bus.m_axis_tready) state_nxt = (tap == 5'd31) ? CALC : SETTLE;
         end
         CALC:       state_nxt = MOVE;
         MOVE: begin
            bus.m_axis_tvalid = |move_mask;
            bus.m_axis_tdata  = move_mask;
            if (!(|move_mask)) state_nxt = DONE;
         end
         default:    state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         tap        <= '0;
         settle_cnt <= '0;
         sample_cnt <= '0;
         fail       <= '0;
         cur_len    <= '0;
         best_len   <= '0;
         cur_start  <= '0;
         best_start <= '0;
         remaining  <= '0;
         lane_ok    <= '0;
         lane_tap   <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  tap        <= '0;
                  settle_cnt <= '0;
                  sample_cnt <= '0;
                  fail       <= '0;
                  cur_len    <= '0;
                  best_len   <= '0;
                  cur_start  <= '0;
                  best_start <= '0;
               end
            end
            SETTLE: begin
               settle_cnt <= (settle_cnt == SETTLE_LAST) ? 8'd0 : settle_cnt + 8'd1;
               sample_cnt <= '0;
            end
            CHECK: begin
               if (bus.s_axis_tvalid) begin
                  fail       <= fail | lane_bad;
                  sample_cnt <= (sample_cnt == SAMPLE_LAST) ? 10'd0 : sample_cnt + 10'd1;
               end
            end
            EVAL: begin
               for (int l = 0; l < 28; l++) begin
                  if (!fail[l]) begin
                     cur_len[l] <= cur_len[l] + 6'd1;
                     if (cur_len[l] == 6'd0) cur_start[l] <= tap;
                     // Strictly longer only, so the earliest of equal windows wins.
                     if (cur_len[l] + 6'd1 > best_len[l]) begin
                        best_len[l]   <= cur_len[l] + 6'd1;
                        best_start[l] <= (cur_len[l] == 6'd0) ? tap : cur_start[l];
                     end
                  end else begin
                     cur_len[l] <= '0;
                  end
               end
               fail <= '0;
            end
            STEP: begin
               if (accept) begin
                  tap        <= tap + 5'd1;
                  settle_cnt <= '0;
               end
            end
            CALC: begin
               remaining <= calc_rem;
               lane_ok   <= calc_ok;
               for (int l = 0; l < 28; l++) begin
                  lane_tap[5*l +: 5] <= calc_rem[l];
               end
            end
            MOVE: begin
               if (accept) begin
                  for (int l = 0; l < 28; l++) begin
                     remaining[l] <= remaining[l] - {4'd0, move_mask[l]};
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_axis_red_pitaya_adc_idelay_trainer.sv
// tb/tb_axis_red_pitaya_adc_idelay_trainer.sv - directed bench with receiver model and window-search reference for the IDELAY trainer
module tb_axis_red_pitaya_adc_idelay_trainer;

   localparam logic [13:0] PAT = 14'h2AAA;

   logic         aclk = 1'b0;
   logic         aresetn;
   logic         start;
   logic         busy;
   logic         done;
   logic [27:0]  lane_ok;
   logic [139:0] lane_tap;

   logic         tready;
   logic         s_valid;
   logic [63:0]  s_data;

   axis_red_pitaya_adc_idelay_trainer_if bus();

   assign bus.m_axis_tready = tready;
   assign bus.s_axis_tvalid = s_valid;
   assign bus.s_axis_tdata  = s_data;

   axis_red_pitaya_adc_idelay_trainer dut (
      .aclk     (aclk),
      .aresetn  (aresetn),
      .start    (start),
      .busy     (busy),
      .done     (done),
      .lane_ok  (lane_ok),
      .lane_tap (lane_tap),
      .bus      (bus)
   );

   always #5 aclk = ~aclk;

   int chk_cnt  = 0;
   int pass_cnt = 0;

   task automatic chk(input string name, input logic [139:0] got, input logic [139:0] want);
      chk_cnt++;
      if (got === want) pass_cnt++;
      else $display("FAIL %s: got %0h, required %0h", name, got, want);
   endtask

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   // Receiver model: per-lane absolute tap position and pass table.
   logic [31:0]  pass_tbl [28];
   int           lane_pos [28];
   logic         rx_clr;
   logic [7:0]   noise;
   logic [13:0]  rx_raw [4];

   always @(posedge aclk) begin
      noise <= 8'($urandom);
      if (rx_clr) begin
         for (int l = 0; l < 28; l++) lane_pos[l] <= 0;
      end else if (bus.m_axis_tvalid && tready) begin
         for (int l = 0; l < 28; l++)
            if (bus.m_axis_tdata[l]) lane_pos[l] <= (lane_pos[l] + 1) % 32;
      end
   end

   always_comb begin
      s_data = '0;
      for (int c = 0; c < 4; c++) begin
         rx_raw[c] = '0;
         for (int k = 0; k < 7; k++) begin
            if (pass_tbl[7*c+k][lane_pos[7*c+k]]) rx_raw[c][2*k +: 2] = PAT[2*k +: 2];
            else                                   rx_raw[c][2*k +: 2] = ~PAT[2*k +: 2];
         end
         s_data[16*c +: 16] = {noise[2*c +: 2], rx_raw[c][13], ~rx_raw[c][12:0]};
      end
   end

   // Reference: longest all-passing contiguous range of trainer taps, earliest on ties.
   logic [27:0]  exp_ok;
   logic [139:0] exp_tap;
   int           exp_max;
   int           run_base;
   int           beats = 0;

   function automatic void model_lane(input logic [31:0] m, input int base,
                                      output logic ok, output logic [4:0] t);
      int bl = 0;
      int bs = 0;
      for (int s = 0; s < 32; s++) begin
         for (int e = s; e < 32; e++) begin
            bit all_pass = 1'b1;
            for (int k = s; k <= e; k++)
               if (!m[(base + k) % 32]) all_pass = 1'b0;
            if (all_pass && (e - s + 1) > bl) begin
               bl = e - s + 1;
               bs = s;
            end
         end
      end
      ok = (bl >= 4);
      t  = ok ? 5'(bs + (bl - 1) / 2) : 5'd0;
   endfunction

   task automatic set_expect();
      logic       ok;
      logic [4:0] t;
      exp_max = 0;
      exp_ok  = '0;
      exp_tap = '0;
      for (int l = 0; l < 28; l++) begin
         model_lane(pass_tbl[l], lane_pos[l], ok, t);
         exp_ok[l]          = ok;
         exp_tap[5*l +: 5]  = t;
         if (int'(t) > exp_max) exp_max = int'(t);
      end
   endtask

   // Compare process: every accepted CE beat, plus mask stability across stalls.
   logic        prev_stall = 1'b0;
   logic [27:0] prev_data  = '0;

   always @(negedge aclk) begin
      if (aresetn) begin
         if (prev_stall) begin
            chk("mask_hold_valid", 140'(bus.m_axis_tvalid), 140'(1'b1));
            chk("mask_hold_data", 140'(bus.m_axis_tdata), 140'(prev_data));
         end
         if (bus.m_axis_tvalid && tready) begin
            int          idx;
            logic [27:0] want;
            idx  = beats - run_base;
            want = '0;
            if (idx < 32) want = '1;
            else
               for (int l = 0; l < 28; l++)
                  want[l] = int'(exp_tap[5*l +: 5]) > (idx - 32);
            chk("beat_mask", 140'(bus.m_axis_tdata), 140'(want));
            beats++;
         end
         prev_stall = bus.m_axis_tvalid && !tready;
         prev_data  = bus.m_axis_tdata;
      end else begin
         prev_stall = 1'b0;
      end
   end

   // Sole driver of tready / s_valid.
   logic stall_req = 1'b0;
   logic gaps_en   = 1'b0;
   logic stall_done;

   initial begin
      tready     = 1'b1;
      s_valid    = 1'b1;
      stall_done = 1'b0;
      forever begin
         tick();
         if (!stall_req) stall_done = 1'b0;
         if (stall_req && !stall_done && (beats - run_base) == 2 && bus.m_axis_tvalid) begin
            stall_done = 1'b1;
            tready     = 1'b0;
            repeat (5) @(posedge aclk);
            #1;
            tready = 1'b1;
         end else begin
            s_valid = gaps_en ? 1'($urandom_range(0, 1)) : 1'b1;
         end
      end
   end

   task automatic start_run(input string name, input bit clr_rx);
      if (clr_rx) begin
         rx_clr = 1'b1;
         tick();
         rx_clr = 1'b0;
         tick();
      end
      set_expect();
      run_base = beats;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk({name, "_busy_rise"}, 140'(busy), 140'(1'b1));
      chk({name, "_done_drop"}, 140'(done), 140'(1'b0));
   endtask

   task automatic finish_run(input string name);
      int n = 0;
      while (!done && n < 30000) begin
         tick();
         n++;
      end
      chk({name, "_done"}, 140'(done), 140'(1'b1));
      chk({name, "_busy_low"}, 140'(busy), 140'(1'b0));
      chk({name, "_beats"}, 140'(beats - run_base), 140'(32 + exp_max));
      chk({name, "_lane_ok"}, 140'(lane_ok), 140'(exp_ok));
      chk({name, "_lane_tap"}, lane_tap, exp_tap);
   endtask

   task automatic fill(input logic [31:0] m);
      for (int l = 0; l < 28; l++) pass_tbl[l] = m;
   endtask

   initial begin
      aresetn  = 1'b0;
      start    = 1'b0;
      rx_clr   = 1'b1;
      run_base = 0;
      fill(32'h0);
      repeat (3) tick();
      chk("rst_busy", 140'(busy), 140'(1'b0));
      chk("rst_done", 140'(done), 140'(1'b0));
      chk("rst_tvalid", 140'(bus.m_axis_tvalid), 140'(1'b0));
      chk("rst_tdata", 140'(bus.m_axis_tdata), 140'(28'h0));
      chk("rst_lane_ok", 140'(lane_ok), 140'(28'h0));
      chk("rst_lane_tap", lane_tap, 140'(0));
      rx_clr  = 1'b0;
      aresetn = 1'b1;
      tick();

      // Taps 10..19 pass everywhere: centre 14.
      fill(32'h000F_FC00);
      start_run("s1", 1'b1);
      finish_run("s1");
      chk("s1_model_pin", exp_tap, {28{5'd14}});
      chk("s1_tap_lit", lane_tap, {28{5'd14}});
      chk("s1_ok_lit", 140'(lane_ok), 140'(28'hFFF_FFFF));

      // Lane 0 too narrow, lane 27 all taps, others never pass; start mid-sweep ignored.
      fill(32'h0);
      pass_tbl[0]  = 32'h0000_0038;
      pass_tbl[27] = 32'hFFFF_FFFF;
      start_run("s2", 1'b1);
      repeat (500) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      finish_run("s2");
      chk("s2_ok_lit", 140'(lane_ok), 140'(28'h800_0000));
      chk("s2_tap27_lit", 140'(lane_tap[139:135]), 140'(5'd15));
      chk("s2_tap0_lit", 140'(lane_tap[4:0]), 140'(5'd0));

      // Equal windows 2..5 and 20..23 on lane 5: earliest kept.
      fill(32'h0);
      pass_tbl[5] = 32'h00F0_003C;
      start_run("s3", 1'b1);
      finish_run("s3");
      chk("s3_tap5_lit", 140'(lane_tap[29:25]), 140'(5'd3));
      chk("s3_ok_lit", 140'(lane_ok), 140'(28'h000_0020));

      // Scenario 1 again with a CE stall on the third sweep beat and sample gaps.
      fill(32'h000F_FC00);
      gaps_en = 1'b1;
      start_run("s4", 1'b1);
      stall_req = 1'b1;
      finish_run("s4");
      stall_req = 1'b0;
      gaps_en   = 1'b0;
      chk("s4_tap_lit", lane_tap, {28{5'd14}});
      chk("s4_ok_lit", 140'(lane_ok), 140'(28'hFFF_FFFF));

      // Reset while checking tap 7, then retrain from the offset left behind.
      start_run("s5a", 1'b1);
      begin
         int n = 0;
         while ((beats - run_base) < 7 && n < 5000) begin
            tick();
            n++;
         end
         chk("s5_reach_tap7", 140'(beats - run_base), 140'(7));
      end
      repeat (30) tick();
      aresetn = 1'b0;
      #1;
      chk("s5_rst_busy", 140'(busy), 140'(1'b0));
      chk("s5_rst_done", 140'(done), 140'(1'b0));
      chk("s5_rst_tvalid", 140'(bus.m_axis_tvalid), 140'(1'b0));
      chk("s5_rst_tdata", 140'(bus.m_axis_tdata), 140'(28'h0));
      chk("s5_rst_lane_ok", 140'(lane_ok), 140'(28'h0));
      chk("s5_rst_lane_tap", lane_tap, 140'(0));
      tick();
      tick();
      aresetn = 1'b1;
      tick();
      start_run("s5", 1'b0);
      finish_run("s5");
      chk("s5_tap_lit", lane_tap, {28{5'd7}});
      chk("s5_final_pos", 140'(lane_pos[13]), 140'(14));

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/axis_red_pitaya_adc_idelay_trainer.md
Name: axis_red_pitaya_adc_idelay_trainer

Overview:
- Automatic IDELAY tap trainer for the 4-channel, 7-lane-per-channel DDR ADC receiver; drives the receiver's 28-bit CE-pulse stream and observes its 64-bit sample stream while the ADC outputs a static test pattern.
- Sweeps all 28 lanes through the 32 increment-only tap positions and records the longest passing window per lane. It then moves each lane to the centre of its window.
- Sits on aclk beside the receiver: trainer master → receiver CE slave; receiver sample master → trainer slave.

Parameters:
- PATTERN, 14'h2AAA, expected raw 14-bit ADC word, identical on all 4 channels.
- SETTLE_CYCLES, 16, aclk cycles waited after a tap step before sampling (covers CE register + IDELAY + IDDR + 2 pipeline regs); range 1..255.
- NUM_SAMPLES, 64, valid samples checked per tap position; range 1..1023.
- MIN_WINDOW, 4, minimum passing-window length (taps) for lane_ok.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that begins training; ignored while busy.
- busy  out  1  high from the cycle after an accepted start until DONE is reached.
- done  out  1  high in DONE, held until the next accepted start.
- lane_ok  out  28  per-lane flag: best window ≥ MIN_WINDOW; valid while done.
- lane_tap  out  28*5  per-lane final tap offset relative to the pre-training tap; lane L is at [5L+4:5L].
- m_axis_tdata  out  28  CE mask, bit L = lane L (channel L/7, raw bits 2·(L%7) and 2·(L%7)+1).
- m_axis_tvalid  out  1  CE transfer valid.
- m_axis_tready  in  1  CE transfer ready.
- s_axis_tdata  in  64  receiver samples, 16 bits per channel.
- s_axis_tvalid  in  1  sample valid.

Behaviour:
- Reset (asynchronous, aresetn=0): FSM=IDLE; busy=0, done=0, m_axis_tvalid=0, m_axis_tdata=0; lane_ok=0, lane_tap=0; all counters and window registers cleared.
- Reset mid-training leaves the receiver taps at an unknown offset; software reruns start. Outputs are still cleared.
- Raw recovery per channel c:
  - raw[12:0] = ~s_axis_tdata[16c+12:16c]
  - raw[13] = s_axis_tdata[16c+13]
  - bits 14/15 are ignored.
- A lane passes a sample if both of its raw bits equal the corresponding PATTERN bits. Only samples with s_axis_tvalid=1 are counted.
- CE transfer: tvalid is asserted with a stable mask until m_axis_tready=1. Each accepted beat is exactly one tap increment, so tvalid drops in the cycle after acceptance unless another beat follows immediately. Taps wrap 31→0.
- FSM states:
  - IDLE: on start → SETTLE with tap=0; clear the fail flags and the current/best windows; done cleared.
  - SETTLE: count SETTLE_CYCLES → CHECK.
  - CHECK: accumulate per-lane sticky fail flags over NUM_SAMPLES valid samples → EVAL.
  - EVAL (1 cycle), per lane:
    - pass: if cur_len=0 then cur_start=tap; cur_len++; if the new cur_len > best_len, copy the current window to best. Strict comparison, so on a tie the earliest window is kept.
    - fail: cur_len=0.
    - In all cases clear the fail flags, then go to STEP.
  - STEP: one CE beat with mask all-ones.
    - On acceptance, if tap<31: tap++ and go to SETTLE.
    - If tap=31, the lanes are back at offset 0; go to CALC.
  - CALC (1 cycle), per lane:
    - ok = best_len ≥ MIN_WINDOW.
    - remaining = ok ? best_start + (best_len−1)/2 (integer) : 0.
    - lane_tap = remaining; lane_ok = ok.
    - Windows do not join across the 31→0 wrap.
  - MOVE: if any remaining ≠ 0, issue a beat with mask = (remaining ≠ 0) and, on acceptance, decrement the masked lanes; repeat. When all are zero → DONE.
  - DONE: done=1, busy=0; start → IDLE path (restart).
- Widths: cur_len and best_len are 6 bits (max 32); start values and tap are 5 bits; the sample counter is 10 bits; the settle counter is 8 bits.
- Latency: with tready=1 and continuous valid samples, total cycles ≈ 32·(SETTLE_CYCLES+NUM_SAMPLES+2) + max(lane_tap) + 3.
- Stalls:
  - s_axis_tvalid low in CHECK stalls the sample count only.
  - tready low in STEP/MOVE stalls the FSM; the mask is held.

Test Plan:
- Lane model passes at taps 10..19 on all lanes, tready=1 → 32 all-ones beats + 14 beats; lane_tap=14 (10+9/2) on all lanes; lane_ok=all-ones; done=1.
- Lane 0 window 3..5, lane 27 window 0..31, others no pass (MIN_WINDOW=4) → lane_ok=28'h8000000; lane_tap[0]=0; lane_tap[27]=15; the MOVE masks contain only bit 27, for 15 beats.
- Two equal windows 2..5 and 20..23 on lane 5 → best_start=2, lane_tap[5]=3.
- tready low for 5 cycles during the third STEP beat, and tvalid gaps in CHECK → mask held stable; exactly 32 sweep beats counted by the model; results identical to the first scenario.
- aresetn asserted during CHECK at tap 7 → all outputs zero in the same cycle; start after release begins a new sweep from tap=0.
- start pulsed while busy → ignored; start in DONE → done drops, busy rises the next cycle, and training repeats.
